stream_mux4v1: RTL and testbench
================================

// Module: stream_mux4v1
// PURPOSE
// - Merges four valid/ready input streams into one output stream: the collecting end of the 1-to-4 demux path.
// - A round-robin arbiter picks the source. The winning beat goes through one output register.
// - out_sel carries the source index, so a downstream 1-to-4 demux can route the beat back by index.
// PARAMETERS
// - WIDTH  8  bit width of each data beat
// PORTS
// - clk        in   1         rising-edge clock, the only clock
// - rst_n      in   1         asynchronous reset, active-low
// - in_data    in   4*WIDTH   channel i occupies in_data[i*WIDTH +: WIDTH]
// - in_valid   in   4         per-channel beat valid
// - in_last    in   4         per-channel end-of-packet flag
// - in_ready   out  4         per-channel accept; combinational
// - out_data   out  WIDTH     registered beat
// - out_sel    out  2         index of the channel that sourced out_data
// - out_last   out  1         registered in_last of the sourcing channel
// - out_valid  out  1         output beat valid
// - out_ready  in   1         downstream accept
// BEHAVIOUR
// - Reset (async assert, sync release): out_valid=0, out_data=0, out_sel=0, out_last=0, rr_ptr=0, lock cleared.
//   in_ready=0 while rst_n=0.
// - load = !out_valid || out_ready. The output register loads only when load=1.
// - Arbitration, combinational: scan channels rr_ptr, rr_ptr+1, ... mod 4. The first one with in_valid=1 wins.
// - Grant is one-hot or zero. in_ready[i] = load && grant[i]. in_ready is never high on more than one channel.
// - Transfer on channel g when in_valid[g] && in_ready[g]. Next edge: out_data<=beat, out_sel<=g, out_last<=in_last[g], out_valid<=1.
// - load=1 with no valid input: out_valid<=0 and out_data/out_sel/out_last hold their previous values.
// - rr_ptr <= (g+1) mod 4 on each arbitration boundary (see CONFIGURATION). It wraps 3 -> 0.
// - Latency: 1 cycle from input handshake to out_valid. Throughput: 1 beat/cycle when out_ready=1 continuously.
// - Backpressure: while out_valid && !out_ready, out_data/out_sel/out_last stay stable and all in_ready=0.
// - Simultaneous out_ready with new input: the old beat leaves and the new one loads on the same edge. No bubble.
// - Fairness: with all 4 channels valid continuously, grants follow 0,1,2,3,0,...
//   Each channel is granted at least once every 4 boundaries.
// - Senders must not drop in_valid without a transfer. The block does not check this.
// - Reset mid-transfer: an in-flight output beat is discarded (out_valid=0). A partially sent packet is not completed.
// CONFIGURATION
// - Macro PACKET_LOCK_EN.
// - Defined:
//   - Once channel g transfers a beat with in_last=0, the arbiter locks to g.
//   - Only g may be granted until its beat with in_last=1 transfers.
//   - rr_ptr advances only on that last beat. The lock clears on the same edge.
//   - While locked and in_valid[g]=0, no channel is granted, even if others are valid.
// - Undefined:
//   - Arbitration happens every beat, and rr_ptr advances on every transfer.
//   - in_last only passes through to out_last.
// - The port list is identical in both builds.
// TESTING
// - Reset: hold rst_n=0 with all in_valid=1 -> in_ready=0, out_valid=0, out_data=0, out_sel=0.
// - Single channel: in_valid=4'b0100, data2=8'hA5, out_ready=1
//   -> next cycle out_valid=1, out_data=8'hA5, out_sel=2. rr_ptr becomes 3.
// - Round robin: all valid, data i=8'h10+i, out_ready=1 for 8 cycles
//   -> out_sel sequence 0,1,2,3,0,1,2,3 with data 10,11,12,13,....
// - Backpressure: out_ready=0 for 3 cycles with beat 8'h3C held
//   -> out_data=8'h3C stable, in_ready=0. After release -> next beat loads on the same edge.
// - Packet lock (PACKET_LOCK_EN): ch1 sends 3 beats with last=0,0,1 while ch0 stays valid
//   -> out_sel=1,1,1, then 0. Without the macro -> out_sel alternates 1,0,1,0.
// - Async reset mid-stream: drop rst_n between edges while out_valid=1
//   -> out_valid=0 immediately. After release -> grants start from channel 0.

Source files
------------

// File: rtl/stream_mux4v1.sv
// stream_mux4v1: merges four valid/ready input streams into one registered
// output stream using a round-robin arbiter. out_sel reports the source
// channel so a downstream 1-to-4 demux can route the beat back.
//
// Optional feature: define PACKET_LOCK_EN to keep the grant on one channel
// from its first beat until its in_last beat has transferred (whole-packet
// arbitration). Without it, arbitration happens on every beat.

module stream_mux4v1 #(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [4*WIDTH-1:0] in_data,
  input  logic [3:0]         in_valid,
  input  logic [3:0]         in_last,
  output logic [3:0]         in_ready,
  output logic [WIDTH-1:0]   out_data,
  output logic [1:0]         out_sel,
  output logic               out_last,
  output logic               out_valid,
  input  logic               out_ready
);

  logic       load;
  logic       found;
  logic       xfer;
  logic [3:0] grant;
  logic [3:0] eligible;
  logic [1:0] gidx;
  logic [1:0] scan_idx;
  logic [1:0] rr_ptr;

`ifdef PACKET_LOCK_EN
  logic       locked;
  logic [1:0] lock_ch;
`endif

  // The output register can take a new beat when empty or when its beat leaves this cycle.
  always_comb begin
    load = !out_valid || out_ready;
  end

  // Round-robin scan starting at rr_ptr; while a packet is locked only its channel is eligible.
  always_comb begin
    grant    = '0;
    gidx     = rr_ptr;
    found    = 1'b0;
    scan_idx = rr_ptr;
    eligible = in_valid;
`ifdef PACKET_LOCK_EN
    if (locked) begin
      eligible = in_valid & (4'b0001 << lock_ch);
    end
`endif
    for (int k = 0; k < 4; k++) begin
      scan_idx = rr_ptr + 2'(k);
      if (!found && eligible[scan_idx]) begin
        found          = 1'b1;
        gidx           = scan_idx;
        grant[scan_idx] = 1'b1;
      end
    end
  end

  // Only the granted channel sees ready, and nothing is accepted while reset is asserted.
  always_comb begin
    in_ready = (rst_n && load) ? grant : 4'b0000;
    xfer     = |(in_valid & in_ready);
  end

  // Output register: capture the winning beat, or go empty when nothing was offered.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_sel   <= 2'd0;
      out_last  <= 1'b0;
    end else if (load) begin
      out_valid <= xfer;
      if (xfer) begin
        out_data <= in_data[gidx*WIDTH +: WIDTH];
        out_sel  <= gidx;
        out_last <= in_last[gidx];
      end
    end
  end

`ifdef PACKET_LOCK_EN
  // Pointer advances only when a packet ends; a non-last beat pins the arbiter to its channel.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr  <= 2'd0;
      locked  <= 1'b0;
      lock_ch <= 2'd0;
    end else if (xfer) begin
      if (in_last[gidx]) begin
        rr_ptr <= gidx + 2'd1;
        locked <= 1'b0;
      end else begin
        locked  <= 1'b1;
        lock_ch <= gidx;
      end
    end
  end
`else
  // Pointer moves past the winner on every transfer, so each beat is arbitrated.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr <= 2'd0;
    end else if (xfer) begin
      rr_ptr <= gidx + 2'd1;
    end
  end
`endif

endmodule

// File: tb/tb_stream_mux4v1.sv
// Directed testbench for stream_mux4v1. Inputs change on the falling edge,
// outputs are sampled 1 time unit after the rising edge. Expected packet-lock
// ordering follows PACKET_LOCK_EN when it is defined for the build.

module tb_stream_mux4v1;

  logic        clk;
  logic        rst_n;
  logic [31:0] in_data;
  logic [3:0]  in_valid;
  logic [3:0]  in_last;
  logic [3:0]  in_ready;
  logic [7:0]  out_data;
  logic [1:0]  out_sel;
  logic        out_last;
  logic        out_valid;
  logic        out_ready;

  int checks;
  int passed;

  stream_mux4v1 #(.WIDTH(8)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_data  (in_data),
    .in_valid (in_valid),
    .in_last  (in_last),
    .in_ready (in_ready),
    .out_data (out_data),
    .out_sel  (out_sel),
    .out_last (out_last),
    .out_valid(out_valid),
    .out_ready(out_ready)
  );

  // Free-running 10-unit clock.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic do_reset();
    @(negedge clk);
    rst_n     = 1'b0;
    in_valid  = 4'b0000;
    in_last   = 4'b1111;
    out_ready = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n     = 1'b0;
    in_valid  = 4'b1111;
    in_last   = 4'b1111;
    in_data   = 32'h44332211;
    out_ready = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    checks++;
    if (in_ready !== 4'b0000) $display("[TB] FAIL reset_in_ready got %b exp 0000", in_ready);
    else passed++;
    checks++;
    if (out_valid !== 1'b0) $display("[TB] FAIL reset_out_valid got %b exp 0", out_valid);
    else passed++;
    checks++;
    if (out_data !== 8'h00) $display("[TB] FAIL reset_out_data got %h exp 00", out_data);
    else passed++;
    checks++;
    if (out_sel !== 2'd0) $display("[TB] FAIL reset_out_sel got %0d exp 0", out_sel);
    else passed++;
    checks++;
    if (out_last !== 1'b0) $display("[TB] FAIL reset_out_last got %b exp 0", out_last);
    else passed++;
    @(negedge clk);
    in_valid = 4'b0000;
    rst_n    = 1'b1;
  endtask

  task automatic test_single_channel();
    do_reset();
    in_valid          = 4'b0100;
    in_data[16 +: 8]  = 8'hA5;
    in_last           = 4'b1111;
    out_ready         = 1'b1;
    #1;
    checks++;
    if (in_ready !== 4'b0100) $display("[TB] FAIL single_in_ready got %b exp 0100", in_ready);
    else passed++;
    @(posedge clk);
    #1;
    in_valid = 4'b0000;
    checks++;
    if (out_valid !== 1'b1) $display("[TB] FAIL single_out_valid got %b exp 1", out_valid);
    else passed++;
    checks++;
    if (out_data !== 8'hA5) $display("[TB] FAIL single_out_data got %h exp a5", out_data);
    else passed++;
    checks++;
    if (out_sel !== 2'd2) $display("[TB] FAIL single_out_sel got %0d exp 2", out_sel);
    else passed++;
    // rr_ptr is now 3, so with everything valid channel 3 must be granted first
    @(negedge clk);
    in_valid = 4'b1111;
    #1;
    checks++;
    if (in_ready !== 4'b1000) $display("[TB] FAIL single_rr_next got %b exp 1000", in_ready);
    else passed++;
    in_valid = 4'b0000;
  endtask

  task automatic test_round_robin();
    do_reset();
    in_data   = 32'h13121110;
    in_last   = 4'b1111;
    in_valid  = 4'b1111;
    out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk);
      #1;
      checks++;
      if (out_valid !== 1'b1 || out_sel !== 2'(i % 4) || out_data !== 8'(8'h10 + i % 4))
        $display("[TB] FAIL rr_beat%0d got v=%b sel=%0d data=%h exp v=1 sel=%0d data=%h",
                 i, out_valid, out_sel, out_data, i % 4, 8'h10 + i % 4);
      else passed++;
    end
    @(negedge clk);
    in_valid = 4'b0000;
  endtask

  task automatic test_backpressure();
    do_reset();
    in_valid         = 4'b0001;
    in_data[0 +: 8]  = 8'h3C;
    in_data[8 +: 8]  = 8'h55;
    in_last          = 4'b1111;
    out_ready        = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    in_valid  = 4'b0010;
    checks++;
    if (out_data !== 8'h3C || out_valid !== 1'b1)
      $display("[TB] FAIL bp_load got v=%b data=%h exp v=1 data=3c", out_valid, out_data);
    else passed++;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      checks++;
      if (out_data !== 8'h3C || out_sel !== 2'd0 || out_valid !== 1'b1 || in_ready !== 4'b0000)
        $display("[TB] FAIL bp_hold%0d got v=%b data=%h sel=%0d rdy=%b exp v=1 data=3c sel=0 rdy=0000",
                 i, out_valid, out_data, out_sel, in_ready);
      else passed++;
    end
    @(negedge clk);
    out_ready = 1'b1;
    #1;
    checks++;
    if (in_ready !== 4'b0010) $display("[TB] FAIL bp_release_ready got %b exp 0010", in_ready);
    else passed++;
    @(posedge clk);
    #1;
    in_valid = 4'b0000;
    checks++;
    if (out_data !== 8'h55 || out_sel !== 2'd1 || out_valid !== 1'b1)
      $display("[TB] FAIL bp_next got v=%b data=%h sel=%0d exp v=1 data=55 sel=1",
               out_valid, out_data, out_sel);
    else passed++;
  endtask

  task automatic test_packet_lock();
    logic [1:0] exp_sel [4];
    int         n1;
    logic [7:0] exp_data;
    logic       exp_last;
`ifdef PACKET_LOCK_EN
    exp_sel = '{2'd1, 2'd1, 2'd1, 2'd0};
`else
    exp_sel = '{2'd1, 2'd0, 2'd1, 2'd0};
`endif
    do_reset();
    // one beat on channel 0 moves the pointer to channel 1
    in_valid         = 4'b0001;
    in_data[0 +: 8]  = 8'h0A;
    in_last          = 4'b1111;
    out_ready        = 1'b1;
    @(posedge clk);
    n1 = 0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      in_data[8 +: 8] = 8'(8'hB0 + n1);
      in_last[1]      = (n1 == 2);
      in_valid        = {2'b00, (n1 < 3), 1'b1};
      @(posedge clk);
      #1;
      exp_data = (exp_sel[k] == 2'd1) ? 8'(8'hB0 + n1) : 8'h0A;
      exp_last = (exp_sel[k] == 2'd1) ? (n1 == 2) : 1'b1;
      checks++;
      if (out_sel !== exp_sel[k] || out_data !== exp_data || out_last !== exp_last || out_valid !== 1'b1)
        $display("[TB] FAIL lock_beat%0d got sel=%0d data=%h last=%b v=%b exp sel=%0d data=%h last=%b v=1",
                 k, out_sel, out_data, out_last, out_valid, exp_sel[k], exp_data, exp_last);
      else passed++;
      if (exp_sel[k] == 2'd1) n1++;
    end
    @(negedge clk);
    in_valid = 4'b0000;
    in_last  = 4'b1111;
  endtask

  task automatic test_async_reset();
    do_reset();
    in_valid         = 4'b0100;
    in_data[16 +: 8] = 8'h77;
    in_last          = 4'b1111;
    out_ready        = 1'b0;
    @(posedge clk);
    #1;
    in_valid = 4'b0000;
    checks++;
    if (out_valid !== 1'b1 || out_data !== 8'h77)
      $display("[TB] FAIL areset_pre got v=%b data=%h exp v=1 data=77", out_valid, out_data);
    else passed++;
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (out_valid !== 1'b0 || out_data !== 8'h00 || in_ready !== 4'b0000)
      $display("[TB] FAIL areset_now got v=%b data=%h rdy=%b exp v=0 data=00 rdy=0000",
               out_valid, out_data, in_ready);
    else passed++;
    @(negedge clk);
    rst_n     = 1'b1;
    in_data   = 32'h13121110;
    in_valid  = 4'b1111;
    out_ready = 1'b1;
    #1;
    checks++;
    if (in_ready !== 4'b0001) $display("[TB] FAIL areset_grant got %b exp 0001", in_ready);
    else passed++;
    @(posedge clk);
    #1;
    checks++;
    if (out_sel !== 2'd0 || out_data !== 8'h10 || out_valid !== 1'b1)
      $display("[TB] FAIL areset_first got sel=%0d data=%h v=%b exp sel=0 data=10 v=1",
               out_sel, out_data, out_valid);
    else passed++;
    @(negedge clk);
    in_valid = 4'b0000;
  endtask

  // Runs every scenario in order, then prints the summary.
  initial begin
    checks    = 0;
    passed    = 0;
    rst_n     = 1'b0;
    in_data   = '0;
    in_valid  = '0;
    in_last   = '0;
    out_ready = 1'b0;
    test_reset();
    test_single_channel();
    test_round_robin();
    test_backpressure();
    test_packet_lock();
    test_async_reset();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
